// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider controller.
package clk_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SWITCH,
        STOP
    } state_t;

    // Smallest ratio that still yields both a high and a low phase.
    localparam int DIV_MIN = 2;

    // Number of high cycles in a period of ratio n (odd n gets the extra cycle).
    // Operates at 32 bits, so counter widths up to 32 are supported.
    function automatic logic [31:0] hi_len(input logic [31:0] n);
        return n - (n >> 1);
    endfunction

endpackage

// File: rtl/clk_div_core.sv
// Period engine: counter, ratio register, registered clk_out/tick, end-of-period flag.
// The controller decides when the counter runs and when a new ratio is loaded.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int DIV_DEFAULT = 2
) (
    input  logic             clk,
    input  logic             reset,          // async, active low
    input  logic             count,          // current state is not IDLE
    input  logic             active,         // next state is not IDLE
    input  logic             load,           // take load_val as the ratio on this edge
    input  logic [CNT_W-1:0] load_val,
    output logic             clk_out,
    output logic             tick,
    output logic             end_of_period
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] div_nxt;

    // Next counter/ratio; IDLE entry, IDLE exit and period wrap all restart at 0.
    always_comb begin
        div_nxt       = load ? load_val : div_q;
        end_of_period = (cnt == div_q - CNT_W'(1));
        cnt_nxt       = '0;
        if (count && active && !end_of_period)
            cnt_nxt = cnt + CNT_W'(1);
    end

    // Outputs are derived from the next counter/ratio so they align with the state edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            div_q   <= CNT_W'(DIV_DEFAULT);
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            div_q   <= div_nxt;
            clk_out <= active && (32'(cnt_nxt) < hi_len(32'(div_nxt)));
            tick    <= active && (cnt_nxt == '0);
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time controller for the programmable clock divider: start/stop on full
// periods and glitch-free ratio changes over a valid/ready handshake.
// Optional: define CLK_DIV_CTRL_PERIOD_CNT_EN to add a saturating 32-bit
// period_cnt output that counts ticks and clears on IDLE entry.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int DIV_DEFAULT = 2
) (
    input  logic             clk,
    input  logic             reset,          // async, active low
    input  logic             en,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic             cfg_err
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    ,
    output logic [31:0]      period_cnt
`endif
);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] pend_q, pend_nxt;
    logic             err_nxt;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic             eop;
    logic             hs;
    logic             legal;

    assign cfg_ready = (state == IDLE) || (state == RUN);
    assign busy      = (state != IDLE);
    assign hs        = cfg_valid && cfg_ready;
    assign legal     = (cfg_div >= CNT_W'(DIV_MIN));

    // Next-state, pending ratio and ratio-load decisions.
    always_comb begin
        state_nxt = state;
        pend_nxt  = pend_q;
        load      = 1'b0;
        load_val  = pend_q;
        err_nxt   = hs && !legal;
        case (state)
            IDLE: begin
                // Ratio loads immediately; if en is also set, RUN starts with it.
                if (hs && legal) begin
                    load     = 1'b1;
                    load_val = cfg_div;
                end
                if (en)
                    state_nxt = RUN;
            end
            RUN: begin
                if (hs && legal) begin
                    pend_nxt  = cfg_div;
                    state_nxt = SWITCH;
                end else if (!en) begin
                    // At the last cycle of a period the period is already complete.
                    state_nxt = eop ? IDLE : STOP;
                end
            end
            SWITCH: begin
                if (eop) begin
                    load      = 1'b1;
                    state_nxt = en ? RUN : IDLE;
                end
            end
            STOP: begin
                if (en)
                    state_nxt = RUN;
                else if (eop)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, pending ratio and error pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            pend_q  <= '0;
            cfg_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            pend_q  <= pend_nxt;
            cfg_err <= err_nxt;
        end
    end

    clk_div_core #(
        .CNT_W       (CNT_W),
        .DIV_DEFAULT (DIV_DEFAULT)
    ) u_core (
        .clk           (clk),
        .reset         (reset),
        .count         (state != IDLE),
        .active        (state_nxt != IDLE),
        .load          (load),
        .load_val      (load_val),
        .clk_out       (clk_out),
        .tick          (tick),
        .end_of_period (eop)
    );

`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    // Saturating tick counter; IDLE entry clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            period_cnt <= '0;
        else if (state != IDLE && state_nxt == IDLE)
            period_cnt <= '0;
        else if (tick && period_cnt != 32'hFFFF_FFFF)
            period_cnt <= period_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl with hand-computed expected waveforms.
module tb_clk_div_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_div;
    logic        clk_out;
    logic        tick;
    logic        busy;
    logic        cfg_err;
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
    logic [31:0] period_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    // Expected per-edge values, bit e = edge e after the entry edge.
    // N=4 then N=7 requested at cnt=1.
    localparam logic [11:0] T3_CLK   = 12'b1000_1111_0011;
    localparam logic [11:0] T3_TICK  = 12'b1000_0001_0001;
    localparam logic [11:0] T3_READY = 12'b1111_1111_0011;
    // N=6, en dropped at cnt=2, runs to IDLE.
    localparam logic [7:0]  T4_CLK   = 8'b0000_0111;
    localparam logic [7:0]  T4_TICK  = 8'b0000_0001;
    localparam logic [7:0]  T4_BUSY  = 8'b0011_1111;
    // N=6, en dropped at cnt=2 and restored in STOP, then illegal ratios 1 and 0.
    localparam logic [12:0] T5_CLK   = 13'b1_0001_1100_0111;
    localparam logic [12:0] T5_TICK  = 13'b1_0000_0100_0001;
    localparam logic [12:0] T5_ERR   = 13'b0_0101_0000_0000;
    localparam logic [12:0] T5_READY = 13'b1_1111_1111_0111;

    always #5 clk = ~clk;

    clk_div_ctrl #(
        .CNT_W       (16),
        .DIV_DEFAULT (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_div    (cfg_div),
        .clk_out    (clk_out),
        .tick       (tick),
        .busy       (busy),
        .cfg_err    (cfg_err)
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
        ,
        .period_cnt (period_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        en        = 1'b0;
        cfg_valid = 1'b0;
        for (int i = 0; i < 64; i++) begin
            step();
            if (!busy) break;
        end
        chk(tag, 32'(busy), 32'd0);
        chk({tag, "_clk"}, 32'(clk_out), 32'd0);
    endtask

    initial begin
        reset     = 1'b0;
        en        = 1'b0;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        step();
        step();

        // Reset state
        chk("rst_clk",   32'(clk_out),   32'd0);
        chk("rst_tick",  32'(tick),      32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_err",   32'(cfg_err),   32'd0);
        chk("rst_ready", 32'(cfg_ready), 32'd1);
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
        chk("rst_pcnt", period_cnt, 32'd0);
`endif

        // Default ratio 2 with en held
        reset = 1'b1;
        en    = 1'b1;
        chk("t1_busy_pre", 32'(busy), 32'd0);
        for (int e = 0; e < 6; e++) begin
            step();
            chk($sformatf("t1_clk%0d", e),  32'(clk_out), 32'((e % 2) == 0));
            chk($sformatf("t1_tick%0d", e), 32'(tick),    32'((e % 2) == 0));
            chk($sformatf("t1_busy%0d", e), 32'(busy),    32'd1);
        end
        wait_idle("t1_idle");

        // Ratio 5 loaded in IDLE, then run
        cfg_valid = 1'b1;
        cfg_div   = 16'd5;
        chk("t2_ready_idle", 32'(cfg_ready), 32'd1);
        step();
        chk("t2_busy_load", 32'(busy), 32'd0);
        chk("t2_clk_load",  32'(clk_out), 32'd0);
        cfg_valid = 1'b0;
        en        = 1'b1;
        for (int e = 0; e < 10; e++) begin
            step();
            chk($sformatf("t2_clk%0d", e),   32'(clk_out),   32'((e % 5) < 3));
            chk($sformatf("t2_tick%0d", e),  32'(tick),      32'((e % 5) == 0));
            chk($sformatf("t2_ready%0d", e), 32'(cfg_ready), 32'd1);
        end
        wait_idle("t2_idle");

        // Start with N=4 loaded with en, switch to N=7 at cnt=1
        en        = 1'b1;
        cfg_valid = 1'b1;
        cfg_div   = 16'd4;
        for (int e = 0; e < 12; e++) begin
            step();
            chk($sformatf("t3_clk%0d", e),   32'(clk_out),   32'(T3_CLK[e]));
            chk($sformatf("t3_tick%0d", e),  32'(tick),      32'(T3_TICK[e]));
            chk($sformatf("t3_ready%0d", e), 32'(cfg_ready), 32'(T3_READY[e]));
            cfg_valid = 1'b0;
            if (e == 1) begin
                cfg_valid = 1'b1;
                cfg_div   = 16'd7;
            end
        end
        wait_idle("t3_idle");

        // N=6, en dropped at cnt=2 -> finishes period, then IDLE
        en        = 1'b1;
        cfg_valid = 1'b1;
        cfg_div   = 16'd6;
        for (int e = 0; e < 8; e++) begin
            step();
            chk($sformatf("t4_clk%0d", e),  32'(clk_out), 32'(T4_CLK[e]));
            chk($sformatf("t4_tick%0d", e), 32'(tick),    32'(T4_TICK[e]));
            chk($sformatf("t4_busy%0d", e), 32'(busy),    32'(T4_BUSY[e]));
            cfg_valid = 1'b0;
            if (e == 2) en = 1'b0;
        end

        // N=6 again: en restored during STOP, then illegal ratios 1 and 0
        en = 1'b1;
        for (int e = 0; e < 13; e++) begin
            step();
            chk($sformatf("t5_clk%0d", e),   32'(clk_out),   32'(T5_CLK[e]));
            chk($sformatf("t5_tick%0d", e),  32'(tick),      32'(T5_TICK[e]));
            chk($sformatf("t5_err%0d", e),   32'(cfg_err),   32'(T5_ERR[e]));
            chk($sformatf("t5_ready%0d", e), 32'(cfg_ready), 32'(T5_READY[e]));
            chk($sformatf("t5_busy%0d", e),  32'(busy),      32'd1);
            cfg_valid = 1'b0;
            case (e)
                2: en = 1'b0;
                3: en = 1'b1;
                7: begin cfg_valid = 1'b1; cfg_div = 16'd1; end
                9: begin cfg_valid = 1'b1; cfg_div = 16'd0; end
                default: ;
            endcase
        end

        // Reset in the middle of a high phase
        reset = 1'b0;
        #1;
        chk("t6_rst_clk",  32'(clk_out), 32'd0);
        chk("t6_rst_tick", 32'(tick),    32'd0);
        chk("t6_rst_busy", 32'(busy),    32'd0);
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
        chk("t6_rst_pcnt", period_cnt, 32'd0);
`endif
        #1;
        reset = 1'b1;
        for (int e = 0; e < 4; e++) begin
            step();
            chk($sformatf("t6_clk%0d", e),  32'(clk_out), 32'((e % 2) == 0));
            chk($sformatf("t6_tick%0d", e), 32'(tick),    32'((e % 2) == 0));
        end
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
        chk("t6_pcnt_run", period_cnt, 32'd2);
`endif
        wait_idle("t6_idle");
`ifdef CLK_DIV_CTRL_PERIOD_CNT_EN
        chk("t6_pcnt_idle", period_cnt, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
- Run-time controller for the programmable clock divider.
- Starts and stops the divided clock cleanly, always ending on a low phase.
- Accepts new divide ratios over a valid/ready handshake and applies each one only at a period boundary, so clk_out never produces a runt pulse.
- Sits between the config/CSR logic and every consumer of the divided clock or its enable tick.

Parameters:
- CNT_W, 16: width of the divide ratio and the internal counter.
- DIV_DEFAULT, 2: divide ratio loaded at reset. Must be >= 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  run request, level-sensitive.
- cfg_valid  in  1  new-ratio request.
- cfg_ready  out  1  controller can accept a ratio.
- cfg_div  in  CNT_W  requested ratio N; legal range 2..2^CNT_W-1.
- clk_out  out  1  divided clock, registered.
- tick  out  1  one-cycle pulse at the start of each divided period.
- busy  out  1  state != IDLE.
- cfg_err  out  1  one-cycle pulse when an illegal ratio is dropped.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, cnt=0, div_q=DIV_DEFAULT, pend_q=0.
  - clk_out=0, tick=0, cfg_err=0, busy=0.
- Period shape for ratio N = div_q:
  - cnt runs 0..N-1 and wraps to 0.
  - clk_out is high while cnt < N-floor(N/2), low otherwise.
  - Odd N gives one extra high cycle. Example: N=5 gives 3 high, 2 low.
  - tick=1 exactly in the cycles where cnt==0 and state is RUN, SWITCH or STOP.
- Outputs are registered: clk_out and tick update on the same edge that the state/cnt update.
- IDLE:
  - clk_out=0, tick=0.
  - en sampled 1: next state RUN, cnt=0, clk_out=1, tick=1 (first high cycle coincides with the entry edge).
- RUN:
  - cnt increments.
  - en=0: go to STOP; the current period completes.
  - A handshake: latch cfg_div into pend_q and go to SWITCH.
  - If en=0 and a handshake occur in the same cycle: take the handshake, go to SWITCH.
- SWITCH:
  - Applies at the end-of-period cycle (cnt==div_q-1): div_q<=pend_q, cnt<=0.
  - Next state after that edge is RUN if en=1, else IDLE with clk_out=0.
- STOP:
  - en=1 again: return to RUN with no gap and no cnt reset.
  - At end of period: go to IDLE, cnt=0.
  - clk_out therefore always ends after a full low phase.
- Handshake:
  - cfg_ready=1 in IDLE and RUN; 0 in SWITCH and STOP.
  - Transfer occurs when cfg_valid && cfg_ready.
  - In IDLE, the accepted ratio loads div_q on the next edge with no state change. If en=1 in the same cycle, RUN starts with the new ratio.
- Illegal ratio (cfg_div < 2):
  - The handshake completes, but the value is discarded.
  - cfg_err=1 for the next cycle; state and div_q are unchanged.
- Edge cases:
  - A new ratio equal to div_q still passes through SWITCH (one full period, no visible change).
  - Reset mid-period forces clk_out=0 immediately; the partial pulse is allowed only because of reset.

Optional Feature:
- Macro: CLK_DIV_CTRL_PERIOD_CNT_EN.
- Defined: adds output period_cnt (32 bits).
  - Increments on every tick.
  - Saturates at 0xFFFFFFFF.
  - Clears on reset and on every entry to IDLE.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package clk_div_pkg:
  - state typedef enum {IDLE, RUN, SWITCH, STOP}.
  - Constant DIV_MIN=2.
  - Helper function hi_len(N) = N - N/2.
- Sub-module clk_div_core:
  - Contains the counter, clk_out/tick generation, a load strobe with load value, and an end_of_period output.
  - The FSM and handshake stay in clk_div_ctrl.

Test Plan:
- Reset default, en=1 held: clk_out period is 2 cycles, 1 high/1 low. tick on every even cycle. busy=1 one edge after en rises.
- Ratio 5 in IDLE, then en=1: 3 high, 2 low. tick every 5 cycles. cfg_ready=1 throughout.
- Running N=4, request N=7 at cnt=1:
  - cfg_ready drops for the rest of that period.
  - The N=4 period completes intact.
  - The next period is 7 cycles (4 high, 3 low), then RUN.
- Running N=6, en=0 at cnt=2: clk_out completes its high/low phase, state goes IDLE at cnt wrap, clk_out stays 0. Reassert en during STOP: no gap in the period train.
- cfg_div=1 or 0 with cfg_valid=1: handshake completes, cfg_err pulses for exactly 1 cycle, ratio unchanged.
- Assert reset mid-high-phase: clk_out=0 immediately, div_q=2. With the macro defined, period_cnt counts ticks, clears on reset, and clears when IDLE is entered.
